// File: rtl/uart_tx_scheduler.sv
// Round-robin arbitration of two byte requesters into a small FIFO, drained one
// frame at a time over the transmitter's CONTROL/DATA/STATUS handshake.
module uart_tx_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AW          = 2,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter logic [7:0]  RDY         = 8'd0,
  parameter logic [7:0]  BSY         = 8'd255,
  parameter logic [7:0]  NOP         = 8'd0,
  parameter logic [7:0]  SND         = 8'd255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0_VALID,
  input  logic [7:0]  REQ0_DATA,
  output logic        REQ0_READY,
  input  logic        REQ1_VALID,
  input  logic [7:0]  REQ1_DATA,
  output logic        REQ1_READY,
  input  logic [7:0]  TX_STATUS,
  output logic [7:0]  TX_CONTROL,
  output logic [7:0]  TX_DATA,
  input  logic        ERR_CLR,
  output logic [AW:0] COUNT,
  output logic        BUSY,
  output logic        ERR
);

  localparam int unsigned TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BSY, WAIT_RDY} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          rr;
  logic          full, empty;
  logic          grant0, grant1;
  logic          push, pop;
  logic [7:0]    push_data;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [7:0]    ctrl, ctrl_nxt;
  logic [7:0]    data, data_nxt;
  logic          err, err_set;

  // Fullness is taken from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign grant0 = REQ0_VALID & (~REQ1_VALID | ~rr);
  assign grant1 = REQ1_VALID & (~REQ0_VALID | rr);
  assign REQ0_READY = grant0 & ~full;
  assign REQ1_READY = grant1 & ~full;
  assign push      = REQ0_READY | REQ1_READY;
  assign push_data = REQ0_READY ? REQ0_DATA : REQ1_DATA;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr     <= REQ0_READY;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl_nxt  = ctrl;
    data_nxt  = data;
    timer_nxt = timer;
    pop       = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        ctrl_nxt = NOP;
        if (!empty && TX_STATUS == RDY) begin
          data_nxt  = mem[rd_ptr];
          ctrl_nxt  = SND;
          pop       = 1'b1;
          timer_nxt = '0;
          state_nxt = WAIT_BSY;
        end
      end
      WAIT_BSY: begin
        if (TX_STATUS == BSY) begin
          ctrl_nxt  = NOP;
          state_nxt = WAIT_RDY;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          ctrl_nxt  = NOP;
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      WAIT_RDY: begin
        ctrl_nxt = NOP;
        if (TX_STATUS == RDY) state_nxt = IDLE;
      end
      default: begin
        ctrl_nxt  = NOP;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ctrl  <= NOP;
      data  <= '0;
      timer <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_nxt;
      data  <= data_nxt;
      timer <= timer_nxt;
      err   <= err_set | (err & ~ERR_CLR);
    end
  end

  assign TX_CONTROL = ctrl;
  assign TX_DATA    = data;
  assign COUNT      = count;
  assign BUSY       = ~empty | (state != IDLE);
  assign ERR        = err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model with a behavioural transmitter.
module tb_uart_tx_scheduler;
  localparam int DEPTH = 4;
  localparam logic [7:0] SND_C = 8'hFF;
  localparam logic [7:0] NOP_C = 8'h00;
  localparam logic [7:0] RDY_C = 8'h00;
  localparam logic [7:0] BSY_C = 8'hFF;
  localparam int TXN = 0;  // responsive transmitter
  localparam int TXS = 1;  // stuck at RDY, never acknowledges
  localparam int TXH = 2;  // holds an unrelated status code

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
  logic [7:0] REQ0_DATA, REQ1_DATA;
  logic [7:0] TX_STATUS, TX_CONTROL, TX_DATA;
  logic       ERR_CLR, BUSY, ERR;
  logic [2:0] COUNT;

  always #5 CLK = ~CLK;

  uart_tx_scheduler #(
    .DEPTH(4), .AW(2), .ACK_TIMEOUT(16),
    .RDY(8'h00), .BSY(8'hFF), .NOP(8'h00), .SND(8'hFF)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
    .TX_STATUS(TX_STATUS), .TX_CONTROL(TX_CONTROL), .TX_DATA(TX_DATA),
    .ERR_CLR(ERR_CLR), .COUNT(COUNT), .BUSY(BUSY), .ERR(ERR)
  );

  int total = 0;
  int bad   = 0;

  int         tx_mode, tx_cnt, bsy_len;
  bit         tx_rand;
  bit         prev_snd;
  logic [7:0] sent[$];
  logic [7:0] mq[$];
  int         m_cnt, n0, n1, lim0, lim1;
  bit         m_rr, saw_full;
  logic [7:0] base0, base1;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    logic [2:0] cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_tx(input int mode);
    tx_mode = mode;
    tx_cnt  = 0;
    TX_STATUS = (mode == TXH) ? 8'h55 : RDY_C;
  endtask

  // Transmitter: acknowledges SND with BSY for a number of cycles, then RDY.
  task automatic tx_step();
    if (tx_mode == TXN) begin
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) TX_STATUS = RDY_C;
      end else if (TX_CONTROL == SND_C && TX_STATUS == RDY_C) begin
        TX_STATUS = BSY_C;
        tx_cnt = tx_rand ? int'($urandom_range(1, 4)) : bsy_len;
      end
    end else if (tx_mode == TXS) begin
      TX_STATUS = RDY_C;
    end else begin
      TX_STATUS = 8'h55;
    end
  endtask

  task automatic post_edge(output bit rose);
    rose = (TX_CONTROL == SND_C) && !prev_snd;
    if (rose) sent.push_back(TX_DATA);
    prev_snd = (TX_CONTROL == SND_C);
    tx_step();
  endtask

  task automatic cyc();
    bit r;
    @(posedge CLK); #1;
    post_edge(r);
  endtask

  task automatic model_reset();
    mq.delete();
    sent.delete();
    m_cnt = 0; m_rr = 0; n0 = 0; n1 = 0;
    prev_snd = 0; saw_full = 0;
  endtask

  task automatic reset_dut();
    REQ0_VALID = 0; REQ1_VALID = 0; REQ0_DATA = '0; REQ1_DATA = '0; ERR_CLR = 0;
    set_tx(TXN);
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    model_reset();
  endtask

  // pattern 0: persistent requesters with incrementing streams; 1: random traffic.
  task automatic run_model(input int pattern, input int min_cyc, input int budget);
    bit v0, v1, g0, g1, full, rose, done;
    logic [7:0] d0, d1;
    int pre;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      if (pattern == 0) begin
        v0 = (n0 < lim0); v1 = (n1 < lim1);
        d0 = base0 + 8'(n0); d1 = base1 + 8'(n1);
      end else begin
        v0 = (c < min_cyc) && ($urandom_range(0, 2) != 0);
        v1 = (c < min_cyc) && ($urandom_range(0, 1) != 0);
        d0 = 8'($urandom); d1 = 8'($urandom);
      end
      REQ0_VALID = v0; REQ0_DATA = d0; REQ1_VALID = v1; REQ1_DATA = d1;
      #3;
      full = (m_cnt == DEPTH);
      g0 = v0 && (!v1 || !m_rr);
      g1 = v1 && (!v0 || m_rr);
      chk("ready0", REQ0_READY, g0 && !full);
      chk("ready1", REQ1_READY, g1 && !full);
      pre = mq.size();
      @(posedge CLK); #1;
      if (!full && g0) begin mq.push_back(d0); m_rr = 1; m_cnt++; n0++; end
      else if (!full && g1) begin mq.push_back(d1); m_rr = 0; m_cnt++; n1++; end
      post_edge(rose);
      if (rose) begin
        chk("pop_when_nonempty", pre > 0, 1);
        if (pre > 0) begin
          chk("tx_data_order", TX_DATA, mq[0]);
          void'(mq.pop_front());
          m_cnt--;
        end
      end
      chk("count", COUNT, m_cnt);
      if (m_cnt == DEPTH) saw_full = 1;
      done = ((pattern == 0) ? (n0 >= lim0 && n1 >= lim1) : (c >= min_cyc))
             && mq.size() == 0 && !BUSY;
    end
    REQ0_VALID = 0; REQ1_VALID = 0;
    chk("run_completes", done, 1);
  endtask

  // mode 0: no clear; 1: clear early in the frame; 2: clear held across the timeout edge.
  task automatic timeout_frame(input int mode, input logic [7:0] exp);
    int w, held;
    w = 0; held = 0;
    while (TX_CONTROL != SND_C && w < 10) begin cyc(); w++; end
    chk("to_issue_wait", w, 1);
    chk("to_data", TX_DATA, exp);
    while (TX_CONTROL == SND_C && held < 40) begin
      ERR_CLR = (mode == 1 && held == 2) || (mode == 2 && held >= 14);
      cyc(); held++;
      if (mode == 1 && held == 3)  chk("err_clr", ERR, 0);
      if (mode == 2 && held == 15) chk("err_clr_before_to", ERR, 0);
    end
    ERR_CLR = 0;
    chk("snd_held_cycles", held, 16);
    chk("err_after_to", ERR, 1);
    chk("nop_after_to", TX_CONTROL, NOP_C);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[7];
    logic [7:0] exp_fifo[5];
    int         w;
    bit         r;

    tbl = '{
      '{1'b1, 8'h01, 1'b1, 8'h81, 1'b1, 1'b0, 3'd1},
      '{1'b1, 8'h02, 1'b1, 8'h82, 1'b0, 1'b1, 3'd2},
      '{1'b0, 8'h03, 1'b1, 8'h83, 1'b0, 1'b1, 3'd3},
      '{1'b1, 8'h04, 1'b1, 8'h84, 1'b1, 1'b0, 3'd4},
      '{1'b1, 8'h05, 1'b1, 8'h85, 1'b0, 1'b0, 3'd4},
      '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4},
      '{1'b0, 8'h00, 1'b1, 8'h87, 1'b0, 1'b0, 3'd4}
    };
    exp_fifo = '{8'h01, 8'h82, 8'h83, 8'h04, 8'h77};

    REQ0_VALID = 0; REQ1_VALID = 0; REQ0_DATA = '0; REQ1_DATA = '0; ERR_CLR = 0;
    bsy_len = 3; tx_rand = 0;
    set_tx(TXN);
    model_reset();

    // Asynchronous reset before any clock edge
    #1 RST = 1;
    #2;
    chk("rst_count", COUNT, 0);
    chk("rst_ctrl", TX_CONTROL, NOP_C);
    chk("rst_data", TX_DATA, 0);
    chk("rst_err", ERR, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ready0", REQ0_READY, 0);
    @(posedge CLK); #1;
    RST = 0;

    // Single frame latency and handshake
    REQ0_VALID = 1; REQ0_DATA = 8'hA5;
    #3;
    chk("single_ready", REQ0_READY, 1);
    @(posedge CLK); #1;
    REQ0_VALID = 0;
    post_edge(r);
    chk("single_count", COUNT, 1);
    chk("single_ctrl_pre", TX_CONTROL, NOP_C);
    cyc();
    chk("single_snd", TX_CONTROL, SND_C);
    chk("single_data", TX_DATA, 8'hA5);
    chk("single_count_pop", COUNT, 0);
    chk("single_busy", BUSY, 1);
    cyc();
    chk("single_nop_on_bsy", TX_CONTROL, NOP_C);
    w = 0;
    while (BUSY && w < 20) begin cyc(); w++; end
    chk("single_idle", BUSY, 0);

    // Arbitration and fullness table, transmitter reporting a non-RDY/non-BSY code
    reset_dut();
    set_tx(TXH);
    foreach (tbl[i]) begin
      REQ0_VALID = tbl[i].v0; REQ0_DATA = tbl[i].d0;
      REQ1_VALID = tbl[i].v1; REQ1_DATA = tbl[i].d1;
      #3;
      chk("tbl_ready0", REQ0_READY, tbl[i].r0);
      chk("tbl_ready1", REQ1_READY, tbl[i].r1);
      cyc();
      chk("tbl_count", COUNT, tbl[i].cnt);
      chk("tbl_ctrl_idle", TX_CONTROL, NOP_C);
      chk("tbl_busy", BUSY, 1);
    end

    // Full FIFO popping while a requester waits: no push until the next cycle
    REQ0_VALID = 1; REQ0_DATA = 8'h77; REQ1_VALID = 0;
    set_tx(TXN);
    #3;
    chk("fullpop_ready_blocked", REQ0_READY, 0);
    cyc();
    chk("fullpop_count_dec", COUNT, 3);
    chk("fullpop_snd", TX_CONTROL, SND_C);
    #3;
    chk("fullpop_ready_next", REQ0_READY, 1);
    cyc();
    chk("fullpop_count_refill", COUNT, 4);
    REQ0_VALID = 0;
    w = 0;
    while (BUSY && w < 300) begin cyc(); w++; end
    chk("fullpop_drained", BUSY, 0);
    chk("fullpop_sent_n", sent.size(), 5);
    if (sent.size() == 5)
      foreach (exp_fifo[i]) chk("fullpop_sent", sent[i], exp_fifo[i]);

    // Two persistent requesters alternate
    reset_dut();
    bsy_len = 2; lim0 = 6; lim1 = 6; base0 = 8'h10; base1 = 8'h20;
    run_model(0, 0, 600);
    chk("stream_sent_n", sent.size(), 12);
    if (sent.size() == 12)
      for (int i = 0; i < 12; i++)
        chk("stream_order", sent[i], ((i % 2) ? 8'h20 : 8'h10) + 8'(i / 2));

    // Slow transmitter fills the FIFO
    reset_dut();
    bsy_len = 100; lim0 = 6; lim1 = 0; base0 = 8'h30;
    run_model(0, 0, 1200);
    chk("slow_saw_full", saw_full, 1);
    chk("slow_sent_n", sent.size(), 6);
    if (sent.size() == 6)
      for (int i = 0; i < 6; i++) chk("slow_order", sent[i], 8'h30 + 8'(i));

    // Randomized traffic with random busy lengths
    reset_dut();
    tx_rand = 1;
    run_model(1, 1500, 3000);
    chk("rand_sent_n", sent.size(), n0 + n1);
    tx_rand = 0;

    // Ack timeouts, ERR_CLR, and set-wins on coincidence
    reset_dut();
    set_tx(TXH);
    REQ0_VALID = 1; REQ0_DATA = 8'h5A; cyc();
    REQ0_DATA = 8'h5B; cyc();
    REQ0_DATA = 8'h5C; cyc();
    REQ0_VALID = 0;
    chk("to_count_loaded", COUNT, 3);
    set_tx(TXS);
    timeout_frame(0, 8'h5A);
    timeout_frame(1, 8'h5B);
    timeout_frame(2, 8'h5C);
    chk("to_count_empty", COUNT, 0);
    chk("to_busy_clear", BUSY, 0);

    // Asynchronous reset in WAIT_BSY
    reset_dut();
    set_tx(TXH);
    REQ0_VALID = 1; REQ0_DATA = 8'h66; cyc();
    REQ0_DATA = 8'h67; cyc();
    REQ0_VALID = 0;
    set_tx(TXS);
    cyc(); cyc(); cyc();
    chk("arst_pre_snd", TX_CONTROL, SND_C);
    #2 RST = 1;
    #1;
    chk("arst_ctrl", TX_CONTROL, NOP_C);
    chk("arst_count", COUNT, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_data", TX_DATA, 0);
    @(posedge CLK); #1;
    RST = 0;
    model_reset();
    set_tx(TXN);
    bsy_len = 2; lim0 = 3; lim1 = 3; base0 = 8'h40; base1 = 8'h50;
    run_model(0, 0, 300);
    chk("arst_resume_n", sent.size(), 6);
    if (sent.size() >= 2) begin
      chk("arst_first_req0", sent[0], 8'h40);
      chk("arst_second_req1", sent[1], 8'h50);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
